// File: rtl/pc_sequencer_if.sv
// PC-update request and exception bundle between the control path and the PC sequencer.
interface pc_sequencer_if;
    logic        req_valid;
    logic [2:0]  req_kind;
    logic        branch_taken;
    logic        exc_opcode;
    logic        exc_ovf;
    logic        exc_div0;
    logic        req_ready;
    logic [2:0]  pcsource;
    logic        pc_write;
    logic        epc_write;
    logic        mem_read;
    logic [31:0] vec_addr;
    logic [1:0]  exc_cause;
    logic        busy;

    modport master (
        output req_valid, req_kind, branch_taken, exc_opcode, exc_ovf, exc_div0,
        input  req_ready, pcsource, pc_write, epc_write, mem_read, vec_addr, exc_cause, busy
    );

    modport slave (
        input  req_valid, req_kind, branch_taken, exc_opcode, exc_ovf, exc_div0,
        output req_ready, pcsource, pc_write, epc_write, mem_read, vec_addr, exc_cause, busy
    );
endinterface

// File: rtl/pc_sequencer.sv
// PC sequencer: steers PC source/load for normal flow and runs the exception
// vector fetch (save EPC, read vector, wait for memory, load PC).
module pc_sequencer #(
    parameter int          WAIT_CYCLES = 2,
    parameter logic [31:0] VEC_OPCODE  = 32'd253,
    parameter logic [31:0] VEC_OVF     = 32'd254,
    parameter logic [31:0] VEC_DIV0    = 32'd255
) (
    input  logic              clk,
    input  logic              rst_n,
    pc_sequencer_if.slave     bus
);
    typedef enum logic [2:0] {
        IDLE, ISSUE, EXC_SAVE, EXC_READ, EXC_WAIT, EXC_LOAD
    } state_t;

    state_t      state_reg;
    logic [2:0]  pend_reg;      // bit0 opcode, bit1 overflow, bit2 div0
    logic [2:0]  kind_reg;
    logic        taken_reg;
    logic [2:0]  cnt_reg;
    logic [1:0]  cause_reg;

    logic [2:0]  exc_in;
    logic [2:0]  pend_all;
    logic [2:0]  sel_mask;
    logic [1:0]  sel_cause;
    logic [31:0] vec_sel;

    assign exc_in   = {bus.exc_div0, bus.exc_ovf, bus.exc_opcode};
    assign pend_all = pend_reg | exc_in;

    always_comb begin
        sel_mask  = 3'b000;
        sel_cause = 2'b00;
        if (pend_all[0]) begin
            sel_mask  = 3'b001;
            sel_cause = 2'b01;
        end else if (pend_all[1]) begin
            sel_mask  = 3'b010;
            sel_cause = 2'b10;
        end else if (pend_all[2]) begin
            sel_mask  = 3'b100;
            sel_cause = 2'b11;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            pend_reg  <= 3'b000;
            kind_reg  <= 3'b000;
            taken_reg <= 1'b0;
            cnt_reg   <= 3'd0;
            cause_reg <= 2'b00;
        end else begin
            case (state_reg)
                IDLE: begin
                    // Exceptions win over a simultaneous request, which stays unaccepted.
                    if (|pend_all) begin
                        cause_reg <= sel_cause;
                        pend_reg  <= pend_all & ~sel_mask;
                        state_reg <= EXC_SAVE;
                    end else if (bus.req_valid) begin
                        kind_reg  <= bus.req_kind;
                        taken_reg <= bus.branch_taken;
                        state_reg <= ISSUE;
                    end
                end
                ISSUE: begin
                    pend_reg  <= pend_all;
                    state_reg <= IDLE;
                end
                EXC_SAVE: state_reg <= EXC_READ;
                EXC_READ: begin
                    cnt_reg   <= 3'd0;
                    state_reg <= EXC_WAIT;
                end
                EXC_WAIT: begin
                    if (cnt_reg == 3'(WAIT_CYCLES - 1)) begin
                        state_reg <= EXC_LOAD;
                    end else begin
                        cnt_reg <= cnt_reg + 3'd1;
                    end
                end
                EXC_LOAD: state_reg <= IDLE;
                default:  state_reg <= IDLE;
            endcase
        end
    end

    always_comb begin
        case (cause_reg)
            2'b01:   vec_sel = VEC_OPCODE;
            2'b10:   vec_sel = VEC_OVF;
            2'b11:   vec_sel = VEC_DIV0;
            default: vec_sel = 32'd0;
        endcase
    end

    logic [2:0]  pcsource_d;
    logic        pc_write_d;
    logic        epc_write_d;
    logic        mem_read_d;
    logic [31:0] vec_addr_d;

    always_comb begin
        pcsource_d  = 3'b000;
        pc_write_d  = 1'b0;
        epc_write_d = 1'b0;
        mem_read_d  = 1'b0;
        vec_addr_d  = 32'd0;
        case (state_reg)
            ISSUE: begin
                case (kind_reg)
                    3'b000: begin pcsource_d = 3'b000; pc_write_d = 1'b1;      end
                    3'b001: begin pcsource_d = 3'b001; pc_write_d = 1'b1;      end
                    3'b010: begin pcsource_d = 3'b011; pc_write_d = taken_reg; end
                    3'b011: begin pcsource_d = 3'b000; pc_write_d = 1'b1;      end
                    3'b100: begin pcsource_d = 3'b100; pc_write_d = 1'b1;      end
                    default: begin pcsource_d = 3'b000; pc_write_d = 1'b0;     end
                endcase
            end
            EXC_SAVE: epc_write_d = 1'b1;
            EXC_READ: begin
                mem_read_d = 1'b1;
                vec_addr_d = vec_sel;
            end
            EXC_WAIT: vec_addr_d = vec_sel;
            EXC_LOAD: begin
                pcsource_d = 3'b010;
                pc_write_d = 1'b1;
                vec_addr_d = vec_sel;
            end
            default: ;
        endcase
    end

    assign bus.pcsource  = pcsource_d;
    assign bus.pc_write  = pc_write_d;
    assign bus.epc_write = epc_write_d;
    assign bus.mem_read  = mem_read_d;
    assign bus.vec_addr  = vec_addr_d;
    assign bus.exc_cause = cause_reg;
    assign bus.busy      = (state_reg != IDLE);
    assign bus.req_ready = (state_reg == IDLE) && !(|pend_all);
endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: request kinds, exception vectoring, priority, drops and reset.
module tb_pc_sequencer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;

    pc_sequencer_if bus ();

    pc_sequencer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.req_valid    = 1'b0;
        bus.req_kind     = 3'b000;
        bus.branch_taken = 1'b0;
        bus.exc_opcode   = 1'b0;
        bus.exc_ovf      = 1'b0;
        bus.exc_div0     = 1'b0;
    endtask

    // Issue a request from IDLE and check the single ISSUE cycle and return to IDLE.
    task automatic do_req(input string tag, input logic [2:0] kind, input logic taken,
                          input logic [2:0] exp_src, input logic exp_pw);
        bus.req_valid    = 1'b1;
        bus.req_kind     = kind;
        bus.branch_taken = taken;
        chk({tag, "_ready_idle"}, 32'(bus.req_ready), 32'd1);
        tick();
        $display("req kind=%b taken=%b -> pcsource=%b pc_write=%b", kind, taken, bus.pcsource, bus.pc_write);
        chk({tag, "_pcsource"}, 32'(bus.pcsource), 32'(exp_src));
        chk({tag, "_pc_write"}, 32'(bus.pc_write), 32'(exp_pw));
        chk({tag, "_ready_issue"}, 32'(bus.req_ready), 32'd0);
        clear_inputs();
        tick();
        chk({tag, "_ready_after"}, 32'(bus.req_ready), 32'd1);
        chk({tag, "_pw_after"}, 32'(bus.pc_write), 32'd0);
    endtask

    // Called in IDLE with an exception visible; walks SAVE/READ/WAIT x2/LOAD/IDLE.
    task automatic exc_seq(input string tag, input logic [1:0] cause, input logic [31:0] vec);
        tick();
        chk({tag, "_save_epc"}, 32'(bus.epc_write), 32'd1);
        chk({tag, "_save_cause"}, 32'(bus.exc_cause), 32'(cause));
        chk({tag, "_save_pw"}, 32'(bus.pc_write), 32'd0);
        chk({tag, "_save_busy"}, 32'(bus.busy), 32'd1);
        clear_inputs();
        tick();
        chk({tag, "_read_epc"}, 32'(bus.epc_write), 32'd0);
        chk({tag, "_read_mem"}, 32'(bus.mem_read), 32'd1);
        chk({tag, "_read_vec"}, bus.vec_addr, vec);
        for (int i = 0; i < 2; i++) begin
            tick();
            chk({tag, "_wait_mem"}, 32'(bus.mem_read), 32'd0);
            chk({tag, "_wait_vec"}, bus.vec_addr, vec);
            chk({tag, "_wait_pw"}, 32'(bus.pc_write), 32'd0);
        end
        tick();
        chk({tag, "_load_src"}, 32'(bus.pcsource), 32'd2);
        chk({tag, "_load_pw"}, 32'(bus.pc_write), 32'd1);
        chk({tag, "_load_vec"}, bus.vec_addr, vec);
        tick();
        $display("exc %s cause=%b vec=%0d serviced", tag, cause, vec);
        chk({tag, "_end_pw"}, 32'(bus.pc_write), 32'd0);
        chk({tag, "_end_vec"}, bus.vec_addr, 32'd0);
        chk({tag, "_end_busy"}, 32'(bus.busy), 32'd0);
        chk({tag, "_end_cause"}, 32'(bus.exc_cause), 32'(cause));
    endtask

    initial begin
        clear_inputs();
        #1;
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_ready", 32'(bus.req_ready), 32'd1);
        chk("rst_pw", 32'(bus.pc_write), 32'd0);
        chk("rst_vec", bus.vec_addr, 32'd0);
        chk("rst_cause", 32'(bus.exc_cause), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        do_req("seq", 3'b000, 1'b0, 3'b000, 1'b1);
        do_req("jump", 3'b001, 1'b0, 3'b001, 1'b1);
        do_req("br_nt", 3'b010, 1'b0, 3'b011, 1'b0);
        do_req("br_t", 3'b010, 1'b1, 3'b011, 1'b1);
        do_req("jr", 3'b011, 1'b1, 3'b000, 1'b1);
        do_req("rte", 3'b100, 1'b0, 3'b100, 1'b1);
        do_req("rsv", 3'b101, 1'b1, 3'b000, 1'b0);
        chk("rsv_no_exc_busy", 32'(bus.busy), 32'd0);
        chk("rsv_no_exc_cause", 32'(bus.exc_cause), 32'd0);

        // Overflow beats a simultaneous request.
        bus.req_valid = 1'b1;
        bus.req_kind  = 3'b001;
        bus.exc_ovf   = 1'b1;
        #1;
        chk("ovf_req_rejected", 32'(bus.req_ready), 32'd0);
        exc_seq("ovf", 2'b10, 32'd254);
        chk("ovf_ready", 32'(bus.req_ready), 32'd1);

        // Opcode and div0 together: opcode first, div0 follows automatically.
        bus.exc_opcode = 1'b1;
        bus.exc_div0   = 1'b1;
        exc_seq("opc", 2'b01, 32'd253);
        chk("div0_pending_ready", 32'(bus.req_ready), 32'd0);
        exc_seq("div0", 2'b11, 32'd255);
        chk("div0_done_ready", 32'(bus.req_ready), 32'd1);

        // Reset pulsed during EXC_WAIT, with div0 also pending.
        bus.exc_ovf  = 1'b1;
        bus.exc_div0 = 1'b1;
        tick();
        clear_inputs();
        tick();
        tick();
        chk("rw_in_wait_vec", bus.vec_addr, 32'd254);
        #2;
        rst_n = 1'b0;
        #1;
        $display("async reset mid-wait: busy=%b vec=%0d", bus.busy, bus.vec_addr);
        chk("rw_busy", 32'(bus.busy), 32'd0);
        chk("rw_vec", bus.vec_addr, 32'd0);
        chk("rw_mem", 32'(bus.mem_read), 32'd0);
        chk("rw_ready", 32'(bus.req_ready), 32'd1);
        chk("rw_cause", 32'(bus.exc_cause), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("rw_post_busy", 32'(bus.busy), 32'd0);
            chk("rw_post_pw", 32'(bus.pc_write), 32'd0);
        end

        // Exception pulsed during EXC_WAIT is dropped.
        bus.exc_div0 = 1'b1;
        tick();
        clear_inputs();
        tick();
        tick();
        bus.exc_opcode = 1'b1;
        tick();
        bus.exc_opcode = 1'b0;
        tick();
        chk("drop_load_pw", 32'(bus.pc_write), 32'd1);
        chk("drop_load_vec", bus.vec_addr, 32'd255);
        tick();
        chk("drop_ready", 32'(bus.req_ready), 32'd1);
        tick();
        chk("drop_busy", 32'(bus.busy), 32'd0);
        chk("drop_cause", 32'(bus.exc_cause), 32'd3);

        // Exception arriving during ISSUE is latched and serviced next.
        bus.req_valid = 1'b1;
        bus.req_kind  = 3'b100;
        tick();
        chk("iss_pw", 32'(bus.pc_write), 32'd1);
        clear_inputs();
        bus.exc_ovf = 1'b1;
        tick();
        bus.exc_ovf = 1'b0;
        #1;
        chk("iss_latched_ready", 32'(bus.req_ready), 32'd0);
        chk("iss_latched_busy", 32'(bus.busy), 32'd0);
        exc_seq("iss_ovf", 2'b10, 32'd254);
        chk("final_ready", 32'(bus.req_ready), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
